uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: four-requester round-robin arbiter feeding one UART
// transmitter. A granted byte is popped from its requester, framed as
// {stop, data, start} and launched with a one-cycle start_tx strobe. The
// arbiter then follows the transmitter's busy handshake and an optional idle
// gap before arbitrating again.
// Optional feature macro: ARB_PKT_LOCK_EN -- when defined, the arbiter stays
// on one requester from a byte with req_last=0 until a byte with req_last=1.
module uart_tx_arbiter #(
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    input  logic [31:0]      req_data,
    input  logic [3:0]       req_last,
    output logic [3:0]       req_ready,
    input  logic             uart_tx_ready,
    input  logic             uart_busy,
    output logic             start_tx,
    output logic [9:0]       tx_frame,
    output logic [1:0]       grant_id,
    output logic             arb_busy,
    output logic [CNT_W-1:0] frame_count
);

    // Gap counter runs 0 .. GAP_CYCLES-1; keep it at least one bit wide.
    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_grant_id;
    logic [1:0]         r_rr_ptr;
    logic [9:0]         r_tx_frame;
    logic [CNT_W-1:0]   r_frame_count;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic [1:0]         w_cand_idx [4];
    logic [3:0]         w_cand_hit;
    logic [1:0]         w_pick_id;
    logic [1:0]         w_grant_sel;
    logic               w_grant_ok;
    logic               w_sel_valid;
    logic [7:0]         w_sel_data;
    logic               w_do_capture;

    // Candidate gi is the requester gi+1 places after the last one served,
    // so candidate 0 has the highest priority this round.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign w_cand_idx[gi] = r_rr_ptr + 2'(gi + 1);
            assign w_cand_hit[gi] = req_valid[w_cand_idx[gi]];
        end
    endgenerate

    // Priority pick: scan from lowest priority up so the first hit wins.
    always_comb begin
        w_pick_id = w_cand_idx[0];
        for (int k = 3; k >= 0; k--) begin
            if (w_cand_hit[k]) begin
                w_pick_id = w_cand_idx[k];
            end
        end
    end

    assign w_sel_valid  = req_valid[r_grant_id];
    assign w_sel_data   = req_data[{r_grant_id, 3'b000} +: 8];
    assign w_do_capture = (r_state == S_CAPTURE) && w_sel_valid;

`ifdef ARB_PKT_LOCK_EN
    logic r_lock;

    // While locked only the current grantee may be served; grant_id still
    // holds it because no other grant can happen in between.
    assign w_grant_ok  = r_lock ? req_valid[r_grant_id] : (|req_valid);
    assign w_grant_sel = r_lock ? r_grant_id : w_pick_id;

    // Lock tracks packet boundaries of captured bytes only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock <= 1'b0;
        end else if (w_do_capture) begin
            r_lock <= ~req_last[r_grant_id];
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = ^req_last;
    assign w_grant_ok    = |req_valid;
    assign w_grant_sel   = w_pick_id;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the one-hot pop strobe.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (uart_tx_ready && w_grant_ok) begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // A requester that withdrew is not popped; re-arbitrate.
                if (w_sel_valid) begin
                    req_ready[r_grant_id] = 1'b1;
                    w_state_next          = S_START;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_START: begin
                w_state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_busy) begin
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_busy) begin
                    w_state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_W'(GAP_LAST_I)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Grant, frame, round-robin pointer and frame counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id    <= 2'd0;
            r_rr_ptr      <= 2'd3;
            r_tx_frame    <= 10'h3FF;
            r_frame_count <= '0;
        end else begin
            if ((r_state == S_IDLE) && (w_state_next == S_CAPTURE)) begin
                r_grant_id <= w_grant_sel;
            end
            if (w_do_capture) begin
                r_tx_frame <= {1'b1, w_sel_data, 1'b0};
            end
            // Pointer moves only for launched frames, so an aborted
            // capture does not cost the requester its turn.
            if (r_state == S_START) begin
                r_frame_count <= r_frame_count + CNT_W'(1);
                r_rr_ptr      <= r_grant_id;
            end
        end
    end

    // Idle gap counter, cleared whenever the arbiter is outside GAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt <= '0;
        end else if (r_state == S_GAP) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end else begin
            r_gap_cnt <= '0;
        end
    end

    assign start_tx    = (r_state == S_START);
    assign arb_busy    = (r_state != S_IDLE);
    assign tx_frame    = r_tx_frame;
    assign grant_id    = r_grant_id;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed vectors, scoreboard queue filled by
// the stimulus and drained by a start_tx monitor. A second instance with a
// 4-bit frame counter shares all inputs to observe counter wrap.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        uart_tx_ready;
    logic        uart_busy;

    logic [3:0]  req_ready;
    logic        start_tx;
    logic [9:0]  tx_frame;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic [15:0] frame_count;

    logic [3:0]  req_ready4;
    logic        start_tx4;
    logic [9:0]  tx_frame4;
    logic [1:0]  grant_id4;
    logic        arb_busy4;
    logic [3:0]  frame_count4;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.GAP_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .uart_tx_ready(uart_tx_ready),
        .uart_busy(uart_busy), .start_tx(start_tx), .tx_frame(tx_frame),
        .grant_id(grant_id), .arb_busy(arb_busy), .frame_count(frame_count)
    );

    uart_tx_arbiter #(.GAP_CYCLES(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready4), .uart_tx_ready(uart_tx_ready),
        .uart_busy(uart_busy), .start_tx(start_tx4), .tx_frame(tx_frame4),
        .grant_id(grant_id4), .arb_busy(arb_busy4), .frame_count(frame_count4)
    );

    typedef struct packed {
        logic [1:0]  g;
        logic [9:0]  f;
        logic [15:0] c;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Expected frame: granted requester, framed byte, counter before launch.
    task automatic push(input logic [1:0] g, input logic [7:0] d);
        exp_t e;
        e.g = g;
        e.f = {1'b1, d, 1'b0};
        e.c = exp_cnt;
        sb_q.push_back(e);
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic wait_capture(output logic [3:0] rdy);
        rdy = 4'b0000;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                rdy = req_ready;
                break;
            end
        end
        checks++;
        if (rdy == 4'b0000) begin
            errors++;
            $display("FAIL capture_timeout actual=no req_ready required=req_ready pulse");
        end
    endtask

    task automatic wait_idle();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!arb_busy) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL idle_timeout actual=arb_busy stuck required=0");
        end
    endtask

    task automatic pop(input logic [3:0] rdy);
        @(posedge clk);
        #1;
        req_valid = req_valid & ~rdy;
    endtask

    // Transmitter model: drop ready on launch, busy for 3 clocks.
    initial begin
        uart_tx_ready = 1'b1;
        uart_busy     = 1'b0;
        forever begin
            @(negedge clk);
            if (start_tx) begin
                uart_tx_ready = 1'b0;
                @(negedge clk);
                uart_busy = 1'b1;
                repeat (3) @(negedge clk);
                uart_busy     = 1'b0;
                uart_tx_ready = 1'b1;
            end
        end
    end

    // Monitor: every launch is compared with the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (start_tx === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start actual=start_tx grant %0d frame %0h required=no launch",
                             grant_id, tx_frame);
                end else begin
                    e = sb_q.pop_front();
                    check("launch_grant", 32'(grant_id), 32'(e.g));
                    check("launch_frame", 32'(tx_frame), 32'(e.f));
                    check("launch_count", 32'(frame_count), 32'(e.c));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rdy;
        int         bytes0;
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        req_last  = 4'b0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_arb_busy", 32'(arb_busy), 32'd0);
        check("rst_tx_frame", 32'(tx_frame), 32'h3FF);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_start_tx", 32'(start_tx), 32'd0);
        rst = 1'b0;

        // Single requester 2, byte A5, exact latency
        push(2'd2, 8'hA5);
        req_data[23:16] = 8'hA5;
        req_valid       = 4'b0100;
        @(negedge clk);
        check("cap_req_ready", 32'(req_ready), 32'h4);
        check("cap_frame_old", 32'(tx_frame), 32'h3FF);
        check("cap_start_low", 32'(start_tx), 32'd0);
        pop(4'b0100);
        @(negedge clk);
        check("start_latency", 32'(start_tx), 32'd1);
        check("start_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("start_one_cycle", 32'(start_tx), 32'd0);
        check("frame_hold", 32'(tx_frame), 32'h34A);
        wait_idle();

        // Requester 1 withdraws during CAPTURE
        req_data  = 32'h0000_7700;
        req_valid = 4'b0010;
        @(negedge clk);
        check("drop_in_capture", 32'(arb_busy), 32'd1);
        req_valid = 4'b0000;
        #1;
        check("drop_no_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("drop_back_idle", 32'(arb_busy), 32'd0);
        check("drop_no_start", 32'(start_tx), 32'd0);
        check("drop_count", 32'(frame_count), 32'd1);
        check("drop_frame_kept", 32'(tx_frame), 32'h34A);
        // Pointer still 2: search starts at 3 so requester 1 beats 2
        req_data = 32'h003C_1E00;
        push(2'd1, 8'h1E);
        push(2'd2, 8'h3C);
        req_valid = 4'b0110;
        wait_capture(rdy);
        check("rr_after_drop", 32'(rdy), 32'h2);
        pop(rdy);
        wait_capture(rdy);
        check("rr_next", 32'(rdy), 32'h4);
        pop(rdy);
        wait_idle();
        check("count_three", 32'(frame_count), 32'd3);

        // Reset while in WAIT_DONE
        req_data[7:0] = 8'h5C;
        push(2'd0, 8'h5C);
        req_valid = 4'b0001;
        wait_capture(rdy);
        pop(rdy);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_arb_busy", 32'(arb_busy), 32'd0);
        check("midrst_tx_frame", 32'(tx_frame), 32'h3FF);
        check("midrst_count", 32'(frame_count), 32'd0);
        check("midrst_grant", 32'(grant_id), 32'd0);
        check("midrst_count4", 32'(frame_count4), 32'd0);
        exp_cnt = 16'd0;
        for (int n = 0; n < 50 && !uart_tx_ready; n++) @(negedge clk);

        // All four valid: grant order 0,1,2,3,0
        req_data = 32'h4433_2211;
        push(2'd0, 8'h11);
        push(2'd1, 8'h22);
        push(2'd2, 8'h33);
        push(2'd3, 8'h44);
        push(2'd0, 8'h11);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_capture(rdy);
            check("rr_order", 32'(rdy), 32'(4'b0001 << (k % 4)));
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        wait_idle();
        check("count_five", 32'(frame_count), 32'd5);

        // Twelve more single frames: 17 since reset
        for (int i = 0; i < 12; i++) begin
            req_data                  = 32'h0;
            req_data[8*(i%4) +: 8]    = 8'h80 + 8'(i);
            push(2'(i % 4), 8'h80 + 8'(i));
            req_valid = 4'(4'b0001 << (i % 4));
            wait_capture(rdy);
            pop(rdy);
            wait_idle();
        end
        check("count_17", 32'(frame_count), 32'd17);
        check("count4_wrap", 32'(frame_count4), 32'd1);

        // Packet of three bytes from requester 0, requester 1 always valid
        req_data = 32'h0000_2010;
        req_last = 4'b0010;
`ifdef ARB_PKT_LOCK_EN
        push(2'd0, 8'h10);
        push(2'd0, 8'h11);
        push(2'd0, 8'h12);
        push(2'd1, 8'h20);
`else
        push(2'd0, 8'h10);
        push(2'd1, 8'h20);
        push(2'd0, 8'h11);
        push(2'd1, 8'h20);
`endif
        bytes0    = 3;
        req_valid = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            wait_capture(rdy);
            @(posedge clk);
            #1;
            if (rdy[0]) begin
                bytes0--;
                req_data[7:0] = 8'h10 + 8'(3 - bytes0);
                req_last[0]   = (bytes0 == 1);
                if (bytes0 == 0) req_valid[0] = 1'b0;
            end
        end
        req_valid = 4'b0000;
        wait_idle();
        check("count_21", 32'(frame_count), 32'd21);
        check("count4_21", 32'(frame_count4), 32'd5);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
